// File: rtl/ph_sender_if.sv
// ph_sender_if
//   Signal bundle between the USB transaction FSM / downstream bit-stuffer and
//   the protocol-handler transmitter (ph_sender).
//
//   Optional feature macro: PH_SENDER_CRC_CORRUPT_EN (adds corrupt_crc).
//
//   Signals:
//     send_OUT/IN/DATA0/ACK/NAK  one-cycle packet requests
//     addr[6:0], endp[3:0]       token fields, latched on accept
//     data[DATA_W-1:0]           DATA0 payload, latched on accept
//     corrupt_crc                (optional) invert last CRC bit of this packet
//     stall                      downstream is inserting a stuffed bit
//     bit_out, bit_valid         decoded serial packet bit stream, LSB-first
//     eop                        downstream must drive SE0
//     busy, pkt_done             packet in progress / one-cycle completion pulse
//
//   Modports:
//     master  requester + downstream side (drives requests and stall)
//     slave   the transmitter itself
interface ph_sender_if #(parameter int DATA_W = 64);
    logic              send_OUT;
    logic              send_IN;
    logic              send_DATA0;
    logic              send_ACK;
    logic              send_NAK;
    logic [6:0]        addr;
    logic [3:0]        endp;
    logic [DATA_W-1:0] data;
`ifdef PH_SENDER_CRC_CORRUPT_EN
    logic              corrupt_crc;
`endif
    logic              stall;
    logic              bit_out;
    logic              bit_valid;
    logic              eop;
    logic              busy;
    logic              pkt_done;

`ifdef PH_SENDER_CRC_CORRUPT_EN
    modport master (
        output send_OUT, send_IN, send_DATA0, send_ACK, send_NAK,
        output addr, endp, data, corrupt_crc, stall,
        input  bit_out, bit_valid, eop, busy, pkt_done
    );
    modport slave (
        input  send_OUT, send_IN, send_DATA0, send_ACK, send_NAK,
        input  addr, endp, data, corrupt_crc, stall,
        output bit_out, bit_valid, eop, busy, pkt_done
    );
`else
    modport master (
        output send_OUT, send_IN, send_DATA0, send_ACK, send_NAK,
        output addr, endp, data, stall,
        input  bit_out, bit_valid, eop, busy, pkt_done
    );
    modport slave (
        input  send_OUT, send_IN, send_DATA0, send_ACK, send_NAK,
        input  addr, endp, data, stall,
        output bit_out, bit_valid, eop, busy, pkt_done
    );
`endif
endinterface

// File: rtl/ph_sender.sv
// ph_sender
//   Transmit side of the USB protocol handler. Accepts one-cycle packet
//   requests (OUT/IN token, DATA0, ACK, NAK) while idle and serialises the
//   packet LSB-first as a decoded bitstream: SYNC, PID, body, CRC, then two
//   cycles of EOP and one gap cycle. The downstream bit-stuffer may stall the
//   stream, which freezes the current bit and all sequencing state.
//
//   Optional feature macro: PH_SENDER_CRC_CORRUPT_EN
//     When defined, bus.corrupt_crc is latched on accept and, if set, the final
//     CRC bit of a token or DATA0 packet is inverted.
//
//   Ports:
//     clock    system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      ph_sender_if.slave (requests, operands, stall, serial outputs)
//
//   Parameters:
//     DATA_W   DATA0 payload width in bits (multiple of 8)
module ph_sender #(
    parameter int DATA_W = 64
) (
    input logic        clock,
    input logic        reset_n,
    ph_sender_if.slave bus
);
    // Counter must reach DATA_W-1 for the payload and 15 for the CRC16.
    localparam int CNT_W  = (DATA_W > 16) ? $clog2(DATA_W) : 5;
    // Body shifter also carries the 11-bit token body.
    localparam int BODY_W = (DATA_W > 11) ? DATA_W : 11;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, DATA, CRC, EOP, GAP} state_t;
    typedef enum logic [1:0] {KIND_HS, KIND_TOKEN, KIND_DATA} kind_t;

    state_t            state;
    state_t            state_nxt;
    kind_t             kind_q;
    kind_t             req_kind;
    logic [3:0]        pid_q;
    logic [3:0]        req_pid;
    logic              req_any;
    logic [BODY_W-1:0] body_q;
    logic [15:0]       crc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              corrupt_q;
    logic              last_bit;
    logic              advance;
    logic              bit_c;
    logic              valid_c;
    logic [3:0]        crc_idx;
    logic [7:0]        pid_byte;

    function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        crc5_next = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc16_next = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Request arbitration: ACK > NAK > DATA0 > OUT > IN.
    always_comb begin
        req_any  = bus.send_ACK | bus.send_NAK | bus.send_DATA0 | bus.send_OUT | bus.send_IN;
        req_pid  = PID_IN;
        req_kind = KIND_TOKEN;
        if (bus.send_ACK) begin
            req_pid  = PID_ACK;
            req_kind = KIND_HS;
        end else if (bus.send_NAK) begin
            req_pid  = PID_NAK;
            req_kind = KIND_HS;
        end else if (bus.send_DATA0) begin
            req_pid  = PID_DATA0;
            req_kind = KIND_DATA;
        end else if (bus.send_OUT) begin
            req_pid  = PID_OUT;
            req_kind = KIND_TOKEN;
        end
    end

    // Last bit of the current serial field.
    always_comb begin
        last_bit = 1'b0;
        case (state)
            SYNC, PID: last_bit = (cnt_q == CNT_W'(7));
            TOKEN:     last_bit = (cnt_q == CNT_W'(10));
            DATA:      last_bit = (cnt_q == CNT_W'(DATA_W - 1));
            CRC:       last_bit = (kind_q == KIND_DATA) ? (cnt_q == CNT_W'(15))
                                                        : (cnt_q == CNT_W'(4));
            default:   last_bit = 1'b0;
        endcase
    end

    assign advance = valid_c & ~bus.stall;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (advance && last_bit) begin
                    state_nxt = PID;
                end
            end
            PID: begin
                if (advance && last_bit) begin
                    if (kind_q == KIND_HS) begin
                        state_nxt = EOP;
                    end else if (kind_q == KIND_TOKEN) begin
                        state_nxt = TOKEN;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            TOKEN, DATA: begin
                if (advance && last_bit) begin
                    state_nxt = CRC;
                end
            end
            CRC: begin
                if (advance && last_bit) begin
                    state_nxt = EOP;
                end
            end
            EOP: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the serial bit is a pure function of state and datapath.
    always_comb begin
        valid_c  = 1'b0;
        bit_c    = 1'b0;
        pid_byte = {~pid_q, pid_q};
        crc_idx  = (kind_q == KIND_DATA) ? (4'd15 - cnt_q[3:0]) : (4'd4 - cnt_q[3:0]);
        case (state)
            SYNC: begin
                valid_c = 1'b1;
                bit_c   = (cnt_q == CNT_W'(7));
            end
            PID: begin
                valid_c = 1'b1;
                bit_c   = pid_byte[cnt_q[2:0]];
            end
            TOKEN, DATA: begin
                valid_c = 1'b1;
                bit_c   = body_q[0];
            end
            CRC: begin
                // CRC goes out complemented, register MSB first.
                valid_c = 1'b1;
                bit_c   = ~crc_q[crc_idx] ^ (corrupt_q & last_bit);
            end
            default: begin
                valid_c = 1'b0;
                bit_c   = 1'b0;
            end
        endcase
    end

    assign bus.bit_out   = bit_c;
    assign bus.bit_valid = valid_c;
    assign bus.eop       = (state == EOP);
    assign bus.busy      = (state != IDLE);
    assign bus.pkt_done  = done_q;

    // Datapath: field counter, body shifter, CRC register, completion pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            kind_q <= KIND_HS;
            pid_q  <= 4'b0000;
            body_q <= '0;
            crc_q  <= 16'h0000;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == GAP);

            if (state_nxt != state) begin
                cnt_q <= '0;
            end else if (advance || state == EOP) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state == IDLE && req_any) begin
                kind_q <= req_kind;
                pid_q  <= req_pid;
                crc_q  <= 16'hFFFF;
                if (req_kind == KIND_DATA) begin
                    body_q <= BODY_W'(bus.data);
                end else begin
                    body_q <= BODY_W'({bus.endp, bus.addr});
                end
            end else if (advance && (state == TOKEN || state == DATA)) begin
                body_q <= body_q >> 1;
                if (state == TOKEN) begin
                    crc_q[4:0] <= crc5_next(crc_q[4:0], body_q[0]);
                end else begin
                    crc_q <= crc16_next(crc_q, body_q[0]);
                end
            end
        end
    end

`ifdef PH_SENDER_CRC_CORRUPT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            corrupt_q <= 1'b0;
        end else if (state == IDLE && req_any) begin
            corrupt_q <= bus.corrupt_crc;
        end
    end
`else
    assign corrupt_q = 1'b0;
`endif

endmodule
